param_data_memory: RTL and testbench

Parametrised successor to the 8-bit, 256-entry single-port data memory: configurable data width and depth, a valid/ready request handshake and registered read data with a valid strobe. It also provides a hardware clear sequence after reset and out-of-range address detection. It sits between the datapath (load/store unit) and storage in the single-cycle/multicycle CPU.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/param_data_memory_if.sv | 34 +++
 rtl/dmem_array.sv | 30 +++
 rtl/param_data_memory.sv | 102 ++++++++++
 tb/tb_param_data_memory.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the parametrised data memory.
//   dmem_state_t : controller state (post-reset clear sweep, then normal run)
//   DMEM_DATA_W  : default data word width
//   DMEM_ADDR_W  : default word address width
package dmem_pkg;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } dmem_state_t;

  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_ADDR_W = 8;

endpackage

// File: rtl/param_data_memory_if.sv
// Request/response bundle between the load/store unit and the data memory.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata  : word address and write data
//   rd_valid/rd_data    : registered read response, one pulse per read
//   err                 : pulse for an accepted out-of-range request
// master = load/store unit side, slave = memory side.
interface param_data_memory_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data, err
  );

endinterface

// File: rtl/dmem_array.sv
// Storage for the data memory: DEPTH words of DATA_W bits, one synchronous
// write port and one synchronous registered read port. No reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read enable and address; rdata updates only when re=1
//   rdata        : registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with valid/ready requests, a
// post-reset clear sweep and out-of-range detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of param_data_memory_if (request + read response)
//   init_done  : high once every word has been written with CLEAR_VAL
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = DMEM_DATA_W,
  parameter int                ADDR_W    = DMEM_ADDR_W,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_data_memory_if.slave    bus,
  output logic                  init_done
);

  // One extra bit so DEPTH == 2**ADDR_W is representable without wrap.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  dmem_state_t       state;
  logic [ADDR_W:0]   clear_ptr;
  logic              ready_q;
  logic              rd_valid_q;
  logic              err_q;
  logic              rd_zero;
  logic              accept;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = {1'b0, bus.req_addr} < DEPTH_X;
  assign accept   = bus.req_valid && ready_q;

  // Write port is owned by the sweep in S_CLEAR and by requests in S_RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata;
    mem_re    = accept && !bus.req_we && in_range;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clear_ptr[ADDR_W-1:0];
      mem_wdata = CLEAR_VAL;
    end else if (accept && bus.req_we && in_range) begin
      mem_we = 1'b1;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (bus.req_addr),
    .rdata (mem_rdata)
  );

  // The storage read register has no reset, so a reset-able flag forces
  // rd_data to zero after reset and after an out-of-range read; the array
  // register only moves on in-range reads, giving the hold behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      clear_ptr  <= '0;
      ready_q    <= 1'b0;
      init_done  <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_zero    <= 1'b1;
    end else begin
      rd_valid_q <= accept && !bus.req_we;
      err_q      <= accept && !in_range;
      if (accept && !bus.req_we) rd_zero <= !in_range;
      if (state == S_CLEAR) begin
        clear_ptr <= clear_ptr + 1'b1;
        if (clear_ptr == LAST) begin
          state     <= S_RUN;
          ready_q   <= 1'b1;
          init_done <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.err       = err_q;
  assign bus.rd_data   = rd_zero ? '0 : mem_rdata;

endmodule

// File: tb/tb_param_data_memory.sv
module tb_param_data_memory;
  import dmem_pkg::*;

  logic clk;
  logic rst_n;
  logic init_a, init_b;
  int   checks;
  int   failures;

  param_data_memory_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
  param_data_memory_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .init_done(init_a));
  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLEAR_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .init_done(init_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: after reset a memory is unavailable for `depth` clock
  // cycles, after which every word holds the clear value (0).
  int         dep   [2];
  int         m_cnt [2];
  logic [7:0] m_mem [2][256];
  logic       m_rdv [2];
  logic [7:0] m_data[2];
  logic       m_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_cnt[i]  = 0;
    m_rdv[i]  = 1'b0;
    m_data[i] = 8'h00;
    m_err[i]  = 1'b0;
    for (int a = 0; a < 256; a++) m_mem[i][a] = 8'h00;
  endtask

  task automatic compare_all(input string tag);
    logic       rdy, ini, rv, er;
    logic [7:0] rd;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        rdy = bus_a.req_ready; ini = init_a; rv = bus_a.rd_valid; rd = bus_a.rd_data; er = bus_a.err;
      end else begin
        rdy = bus_b.req_ready; ini = init_b; rv = bus_b.rd_valid; rd = bus_b.rd_data; er = bus_b.err;
      end
      chk($sformatf("%s_%0d_ready", tag, i), 32'(rdy), 32'(m_cnt[i] >= dep[i]));
      chk($sformatf("%s_%0d_init", tag, i), 32'(ini), 32'(m_cnt[i] >= dep[i]));
      chk($sformatf("%s_%0d_rd_valid", tag, i), 32'(rv), 32'(m_rdv[i]));
      chk($sformatf("%s_%0d_rd_data", tag, i), 32'(rd), 32'(m_data[i]));
      chk($sformatf("%s_%0d_err", tag, i), 32'(er), 32'(m_err[i]));
    end
  endtask

  // Drive one request to both memories, advance one clock, update the model
  // and compare every output of both DUTs.
  task automatic step(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d,
                      input string tag);
    logic rdy, acc;
    bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
    bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else begin
        rdy = m_cnt[i] >= dep[i];
        acc = v && rdy;
        m_rdv[i] = acc && !we;
        m_err[i] = acc && (int'(a) >= dep[i]);
        if (acc && !we) m_data[i] = (int'(a) < dep[i]) ? m_mem[i][a] : 8'h00;
        if (acc && we && int'(a) < dep[i]) m_mem[i][a] = d;
        if (!rdy) m_cnt[i]++;
      end
    end
    #1;
    compare_all(tag);
  endtask

  // Count cycles from reset release until each memory raises req_ready.
  task automatic sweep_check(input bit junk, input string tag);
    int first[2];
    first[0] = -1;
    first[1] = -1;
    for (int k = 1; k <= 600; k++) begin
      if (junk && k < 150) step(1'b1, 1'b1, 8'h05, 8'h55, tag);
      else                 step(1'b0, 1'b0, 8'h00, 8'h00, tag);
      if (first[0] < 0 && bus_a.req_ready) first[0] = k;
      if (first[1] < 0 && bus_b.req_ready) first[1] = k;
      if (first[0] >= 0 && first[1] >= 0) break;
    end
    chk({tag, "_sweep_len_256"}, 32'(first[0]), 32'd256);
    chk({tag, "_sweep_len_200"}, 32'(first[1]), 32'd200);
  endtask

  typedef struct {
    logic       v;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rdv_a;
    logic [7:0] dat_a;
    logic       err_a;
    logic       rdv_b;
    logic [7:0] dat_b;
    logic       err_b;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    dep[0]   = 256;
    dep[1]   = 200;
    model_reset(0);
    model_reset(1);

    //            v     we    addr   wdata  rdv_a dat_a  err_a rdv_b dat_b  err_b
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h01, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h02, 8'h22, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h03, 8'h33, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'hC8, 8'h77, 1'b0, 8'h33, 1'b0, 1'b0, 8'h33, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'hC8, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 8'hC7, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 8'h20, 8'h99, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};

    // Reset state, then first sweep with ignored writes to 0x05.
    rst_n = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, "reset");
    rst_n = 1'b1;
    sweep_check(1'b1, "init");

    // Directed vectors.
    for (int n = 0; n < 19; n++) begin
      step(tbl[n].v, tbl[n].we, tbl[n].addr, tbl[n].wdata, $sformatf("vec%0d", n));
      chk($sformatf("vec%0d_rdv_a", n), 32'(bus_a.rd_valid), 32'(tbl[n].rdv_a));
      chk($sformatf("vec%0d_dat_a", n), 32'(bus_a.rd_data),  32'(tbl[n].dat_a));
      chk($sformatf("vec%0d_err_a", n), 32'(bus_a.err),      32'(tbl[n].err_a));
      chk($sformatf("vec%0d_rdv_b", n), 32'(bus_b.rd_valid), 32'(tbl[n].rdv_b));
      chk($sformatf("vec%0d_dat_b", n), 32'(bus_b.rd_data),  32'(tbl[n].dat_b));
      chk($sformatf("vec%0d_err_b", n), 32'(bus_b.err),      32'(tbl[n].err_b));
    end

    // Random traffic against the model, addresses clustered to hit reuse
    // and the 200-word boundary.
    for (int n = 0; n < 400; n++) begin
      logic       v, we;
      logic [7:0] a, d;
      v  = ($urandom % 4) != 0;
      we = $urandom % 2;
      a  = ($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255));
      d  = 8'($urandom);
      step(v, we, a, d, "rand");
    end

    // Reset right after a read is accepted in S_RUN.
    step(1'b1, 1'b1, 8'h30, 8'h5A, "pre_rst_wr");
    step(1'b1, 1'b0, 8'h30, 8'h00, "pre_rst_rd");
    chk("pre_rst_rd_valid", 32'(bus_a.rd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    compare_all("run_rst_now");
    chk("run_rst_no_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h00, "run_rst_hold");
    rst_n = 1'b1;
    sweep_check(1'b0, "run_rst");
    step(1'b1, 1'b0, 8'h30, 8'h00, "cleared_rd");
    chk("cleared_0x30_a", 32'(bus_a.rd_data), 32'h00);
    chk("cleared_0x30_b", 32'(bus_b.rd_data), 32'h00);

    // Reset during the sweep at clear_ptr = 100.
    step(1'b1, 1'b1, 8'h10, 8'hC3, "pre_sweep_wr");
    step(1'b0, 1'b0, 8'h00, 8'h00, "pre_sweep_idle");
    #2;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    compare_all("sweep_rst0");
    step(1'b0, 1'b0, 8'h00, 8'h00, "sweep_rst0_hold");
    rst_n = 1'b1;
    repeat (100) step(1'b0, 1'b0, 8'h00, 8'h00, "sweep100");
    #2;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    compare_all("sweep_rst_now");
    step(1'b0, 1'b0, 8'h00, 8'h00, "sweep_rst_hold");
    rst_n = 1'b1;
    sweep_check(1'b0, "sweep_rst");
    step(1'b1, 1'b0, 8'h10, 8'h00, "cleared_rd2");
    chk("cleared_0x10_a", 32'(bus_a.rd_data), 32'h00);
    chk("cleared_0x10_valid", 32'(bus_a.rd_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
